io_hub: RTL

Parametrised memory-mapped I/O controller for the single-cycle MIPS core, placed between the datapath's load/store port, the data RAM and NUM_CH byte-stream UART channels. It decodes the I/O window, owns an 8-bit LED register and a status register, and buffers every channel with an RX FIFO and a TX FIFO so the CPU never stalls on UART timing. Loads that fall outside the window return RAM data; stores outside the window pass through as RAM writes.

---
 rtl/io_hub_if.sv | 36 +++
 rtl/io_hub.sv | 117 +++++++++++
 2 files changed

// File: rtl/io_hub_if.sv
// io_hub_if: CPU load/store, data RAM and UART channel signals of io_hub
// Modports: slave is the hub side, master is the CPU/RAM/UART side.
// Optional IO_HUB_IRQ_EN adds the irq line.
interface io_hub_if #(parameter int NUM_CH = 2);
    logic [31:0]         addr;
    logic [31:0]         wdata;
    logic                we;
    logic                re;
    logic [31:0]         rdata;
    logic [31:0]         ram_rdata;
    logic                ram_we;
    logic [7:0]          leds;
    logic [NUM_CH-1:0]   uart_wr;
    logic [8*NUM_CH-1:0] uart_wdata;
    logic [NUM_CH-1:0]   uart_tx_full;
    logic [NUM_CH-1:0]   uart_rd;
    logic [8*NUM_CH-1:0] uart_rdata;
    logic [NUM_CH-1:0]   uart_rx_empty;
`ifdef IO_HUB_IRQ_EN
    logic                irq;
`endif
    modport slave (
        input  addr, wdata, we, re, ram_rdata, uart_tx_full, uart_rdata, uart_rx_empty,
        output rdata, ram_we, leds, uart_wr, uart_wdata, uart_rd
`ifdef IO_HUB_IRQ_EN
        , output irq
`endif
    );
    modport master (
        output addr, wdata, we, re, ram_rdata, uart_tx_full, uart_rdata, uart_rx_empty,
        input  rdata, ram_we, leds, uart_wr, uart_wdata, uart_rd
`ifdef IO_HUB_IRQ_EN
        , input irq
`endif
    );
endinterface

// File: rtl/io_hub.sv
// io_hub: memory-mapped LED/STATUS/UART-FIFO hub between the MIPS load/store port, data RAM and NUM_CH UARTs
// Ports: clk; reset (synchronous, active-high); bus (io_hub_if.slave) with CPU address/data/strobes,
// RAM read data and write enable, LED register, per-channel UART TX/RX handshakes.
// Macro IO_HUB_IRQ_EN: adds IRQ_MASK at offset 0x08 and a registered irq output.
module io_hub #(
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    io_hub_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic                   io_sel;
    logic [7:0]             off;
    logic                   status_rd;
    logic [NUM_CH-1:0]      data_sel, tx_empty, tx_full, rx_empty, rx_full;
    logic [NUM_CH-1:0]      tx_push, tx_pop, rx_push, rx_pop, ovf_set;
    logic [NUM_CH-1:0][7:0] rx_head;
    logic [31:0]            status;
    logic [31:0]            rd;
    logic [7:0]             leds_q, leds_d;
    logic [NUM_CH-1:0]      tx_ovf_q, tx_ovf_d;

    assign io_sel    = bus.addr[31:8] == 24'hFFFFFF;
    assign off       = bus.addr[7:0];
    assign status_rd = bus.re & io_sel & (off == 8'h04);
    assign bus.ram_we  = bus.we & ~io_sel;
    assign bus.leds    = leds_q;
    assign bus.uart_wr = tx_pop;
    assign bus.uart_rd = rx_push;
    // Fullness is judged on the start-of-cycle state, so a full FIFO rejects a push even while draining.
    assign tx_push  = {NUM_CH{bus.we}} & data_sel & ~tx_full;
    assign ovf_set  = {NUM_CH{bus.we}} & data_sel & tx_full;
    assign tx_pop   = ~tx_empty & ~bus.uart_tx_full;
    assign rx_push  = ~bus.uart_rx_empty & ~rx_full;
    assign rx_pop   = {NUM_CH{bus.re}} & data_sel & ~rx_empty;
    assign leds_d   = (bus.we & io_sel & (off == 8'h00)) ? bus.wdata[7:0] : leds_q;
    // A new overflow beats the clear-on-read of STATUS in the same cycle.
    assign tx_ovf_d = ovf_set | (status_rd ? '0 : tx_ovf_q);
    assign status[31:4*NUM_CH] = '0;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [7:0]  tx_mem_q [FIFO_DEPTH];
        logic [7:0]  rx_mem_q [FIFO_DEPTH];
        logic [AW:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
        logic [AW:0] tx_wp_d, tx_rp_d, rx_wp_d, rx_rp_d;
        assign data_sel[c] = io_sel & (off == 8'(16 + 8 * c));
        assign tx_empty[c] = tx_wp_q == tx_rp_q;
        assign rx_empty[c] = rx_wp_q == rx_rp_q;
        // Pointers carry one extra wrap bit: equal index with differing MSB means full.
        assign tx_full[c]  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
        assign rx_full[c]  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
        assign tx_wp_d = tx_wp_q + (AW+1)'(tx_push[c]);
        assign tx_rp_d = tx_rp_q + (AW+1)'(tx_pop[c]);
        assign rx_wp_d = rx_wp_q + (AW+1)'(rx_push[c]);
        assign rx_rp_d = rx_rp_q + (AW+1)'(rx_pop[c]);
        assign rx_head[c] = rx_mem_q[rx_rp_q[AW-1:0]];
        assign bus.uart_wdata[8*c +: 8] = tx_mem_q[tx_rp_q[AW-1:0]];
        assign status[4*c +: 4] = {tx_ovf_q[c], tx_full[c], rx_full[c], rx_empty[c]};
        always_ff @(posedge clk) begin
            if (reset) begin
                tx_wp_q <= '0;
                tx_rp_q <= '0;
                rx_wp_q <= '0;
                rx_rp_q <= '0;
            end else begin
                tx_wp_q <= tx_wp_d;
                tx_rp_q <= tx_rp_d;
                rx_wp_q <= rx_wp_d;
                rx_rp_q <= rx_rp_d;
            end
            if (tx_push[c]) tx_mem_q[tx_wp_q[AW-1:0]] <= bus.wdata[7:0];
            if (rx_push[c]) rx_mem_q[rx_wp_q[AW-1:0]] <= bus.uart_rdata[8*c +: 8];
        end
    end

`ifdef IO_HUB_IRQ_EN
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic              irq_q, irq_d;
    assign mask_d  = (bus.we & io_sel & (off == 8'h08)) ? bus.wdata[NUM_CH-1:0] : mask_q;
    assign irq_d   = |(~rx_empty & mask_q);
    assign bus.irq = irq_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end
`endif

    // Unmapped offsets fall through to zero; an empty RX FIFO reads as zero.
    always_comb begin
        rd = 32'h0;
        if (off == 8'h00) rd = {24'h0, leds_q};
        if (off == 8'h04) rd = status;
`ifdef IO_HUB_IRQ_EN
        if (off == 8'h08) rd = {{(32-NUM_CH){1'b0}}, mask_q};
`endif
        for (int i = 0; i < NUM_CH; i++)
            if (data_sel[i] & ~rx_empty[i]) rd = {24'h0, rx_head[i]};
        bus.rdata = io_sel ? rd : bus.ram_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds_q   <= '0;
            tx_ovf_q <= '0;
        end else begin
            leds_q   <= leds_d;
            tx_ovf_q <= tx_ovf_d;
        end
    end
endmodule
